// File: rtl/plic_claim.sv
// plic_claim: core-side claim/complete controller for plic.
//
// Latches plic's request vector into per-source pending bits. It raises one
// external interrupt to the core, hands out source IDs on claim, and keeps the
// claimed source masked until the core completes it. Only one source is in
// service at a time.
//
// ID 0 means "none"; source k has ID k+1.
//
// Build option:
//   PLIC_CLAIM_EDGE_EN  edge mode. irq_i is registered and a rising edge sets a
//                       sticky pending bit. The bit is held until it is claimed
//                       or its enable drops. An edge that arrives while the
//                       source is in service is held one event deep.
//   (undefined)         level mode. Each pending bit follows the enabled
//                       request level every cycle. The in-service source is
//                       masked.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing pending, nothing in service
// PEND  | at least one source pending, ext_irq_o asserted, awaiting claim
// SERV  | one source claimed and in service, awaiting completion
module plic_claim #(
  parameter int MUN = 4,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MUN-1:0] irq_i,
  input  logic [MUN-1:0] irq_en_i,
  output logic           ext_irq_o,
  input  logic           claim_i,
  output logic           claim_vld_o,
  output logic [IDW-1:0] claim_id_o,
  input  logic           complete_i,
  input  logic [IDW-1:0] complete_id_i,
  output logic [IDW-1:0] active_id_o,
  output logic           cmpl_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [MUN-1:0] pend_q;
  logic [MUN-1:0] pend_d;
  logic [MUN-1:0] pend_set;
  logic [MUN-1:0] claim_clr;
  logic [IDW-1:0] active_id_q;
  logic [IDW-1:0] active_id_d;
  logic           claim_vld_q;
  logic           claim_vld_d;
  logic [IDW-1:0] claim_id_q;
  logic [IDW-1:0] claim_id_d;
  logic           cmpl_err_q;
  logic           cmpl_err_d;
  logic           claim_take;
  logic           pend_any;
  logic [IDW-1:0] sel_id;
  logic [MUN-1:0] sel_onehot;

  assign pend_any = |pend_q;

`ifdef PLIC_CLAIM_EDGE_EN
  logic [MUN-1:0] irq_q;

  // Previous request level, used to detect rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_i;
    end
  end

  // Sticky set on a rising edge. An edge while the source is in service is
  // kept here and presented after completion. Dropping the enable clears it.
  assign pend_set = (pend_q | (irq_i & ~irq_q)) & irq_en_i;
`else
  logic [MUN-1:0] insvc;

  // The gateway mask blocks the source that is currently in service.
  always_comb begin
    insvc = '0;
    for (int k = 0; k < MUN; k++) begin
      insvc[k] = (active_id_q == IDW'(k + 1));
    end
  end

  // Level mode: the pending bit simply follows the enabled request level.
  assign pend_set = irq_i & irq_en_i & ~insvc;
`endif

  // Select the lowest pending index. The loop walks downward, so the lowest
  // set bit is the last one written.
  always_comb begin
    sel_id     = '0;
    sel_onehot = '0;
    for (int k = MUN - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_id     = IDW'(k + 1);
        sel_onehot = '0;
        sel_onehot[k] = 1'b1;
      end
    end
  end

  // A claim in the same cycle as a set of the same bit wins and clears it.
  assign claim_clr = claim_take ? sel_onehot : '0;
  assign pend_d    = pend_set & ~claim_clr;

  // State, pending vector, service ID and registered response strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      active_id_q <= '0;
      claim_vld_q <= 1'b0;
      claim_id_q  <= '0;
      cmpl_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      active_id_q <= active_id_d;
      claim_vld_q <= claim_vld_d;
      claim_id_q  <= claim_id_d;
      cmpl_err_q  <= cmpl_err_d;
    end
  end

  // Next state, claim response, completion handling and error pulse.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    claim_vld_d = 1'b0;
    claim_id_d  = '0;
    cmpl_err_d  = 1'b0;
    claim_take  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        claim_vld_d = claim_i;
        cmpl_err_d  = complete_i;
        if (pend_any) begin
          state_d = ST_PEND;
        end
      end

      ST_PEND: begin
        cmpl_err_d = complete_i;
        if (claim_i) begin
          claim_vld_d = 1'b1;
          if (pend_any) begin
            claim_take  = 1'b1;
            claim_id_d  = sel_id;
            active_id_d = sel_id;
            state_d     = ST_SERV;
          end else begin
            // The pending bits dropped on the same edge as the claim arrived.
            // Nothing is left to hand out.
            state_d = ST_IDLE;
          end
        end else if (!pend_any) begin
          state_d = ST_IDLE;
        end
      end

      ST_SERV: begin
        // No nesting: a claim during service always returns ID 0. A
        // completion in the same cycle is still processed.
        claim_vld_d = claim_i;
        if (complete_i) begin
          if (complete_id_i == active_id_q) begin
            active_id_d = '0;
            state_d     = pend_any ? ST_PEND : ST_IDLE;
          end else begin
            cmpl_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ext_irq_o   = (state_q == ST_PEND);
  assign claim_vld_o = claim_vld_q;
  assign claim_id_o  = claim_id_q;
  assign active_id_o = active_id_q;
  assign cmpl_err_o  = cmpl_err_q;

endmodule

// File: tb/tb_plic_claim.sv
// Testbench for plic_claim: directed vectors, a behavioural reference model
// checked every cycle, and literal expectations at key points.
module tb_plic_claim;

  localparam int MUN = 4;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [MUN-1:0] irq;
  logic [MUN-1:0] irq_en;
  logic           ext_irq_o;
  logic           claim;
  logic           claim_vld_o;
  logic [IDW-1:0] claim_id_o;
  logic           complete;
  logic [IDW-1:0] complete_id;
  logic [IDW-1:0] active_id_o;
  logic           cmpl_err_o;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  plic_claim #(.MUN(MUN), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq),
    .irq_en_i      (irq_en),
    .ext_irq_o     (ext_irq_o),
    .claim_i       (claim),
    .claim_vld_o   (claim_vld_o),
    .claim_id_o    (claim_id_o),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .active_id_o   (active_id_o),
    .cmpl_err_o    (cmpl_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. The controller is in one of three phases:
  // "waiting" (nothing to do), "asking" (interrupt raised), or "serving".
  // Pending is a set of source indices. Claims take the smallest index.
  localparam int PH_WAIT = 0;
  localparam int PH_ASK  = 1;
  localparam int PH_SERV = 2;
  int       m_phase  = PH_WAIT;
  bit [3:0] m_pend   = '0;
  bit [3:0] m_prev   = '0;
  int       m_active = 0;
  bit       m_vld    = 0;
  int       m_cid    = 0;
  bit       m_err    = 0;
  bit [3:0] m_next;
  int       m_low;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = PH_WAIT; m_pend = '0; m_prev = '0; m_active = 0;
      m_vld = 0; m_cid = 0; m_err = 0;
    end else begin
      m_low = -1;
      for (int i = MUN - 1; i >= 0; i--) if (m_pend[i]) m_low = i;
      for (int i = 0; i < MUN; i++) begin
`ifdef PLIC_CLAIM_EDGE_EN
        m_next[i] = irq_en[i] && (m_pend[i] || (irq[i] && !m_prev[i]));
`else
        m_next[i] = irq[i] && irq_en[i] && (m_active != i + 1);
`endif
      end
      m_vld = claim;
      m_cid = 0;
      m_err = 0;
      if (m_phase == PH_WAIT) begin
        m_err = complete;
        if (m_pend != 0) m_phase = PH_ASK;
      end else if (m_phase == PH_ASK) begin
        m_err = complete;
        if (claim && m_low >= 0) begin
          m_cid = m_low + 1;
          m_active = m_low + 1;
          m_next[m_low] = 1'b0;
          m_phase = PH_SERV;
        end else if (m_pend == 0) begin
          m_phase = PH_WAIT;
        end
      end else begin
        if (complete) begin
          if (int'(complete_id) == m_active) begin
            m_active = 0;
            m_phase = (m_pend != 0) ? PH_ASK : PH_WAIT;
          end else begin
            m_err = 1;
          end
        end
      end
      m_pend = m_next;
      m_prev = irq;
    end
  end

  // Compare DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_ext", ext_irq_o, (m_phase == PH_ASK) ? 1 : 0);
      chk("model_vld", claim_vld_o, m_vld);
      chk("model_cid", claim_id_o, m_cid);
      chk("model_act", active_id_o, m_active);
      chk("model_err", cmpl_err_o, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ext(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (!ext_irq_o && n < max_cyc) begin
      tick();
      n++;
    end
    chk(nm, ext_irq_o, 1);
  endtask

  task automatic do_claim();
    claim = 1'b1;
    tick();
    claim = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete = 1'b1;
    complete_id = IDW'(id);
    tick();
    complete = 1'b0;
    complete_id = '0;
  endtask

  initial begin
    rst = 1'b1; irq = 4'b0100; irq_en = 4'hF;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_ext", ext_irq_o, 0);
    chk("rst_act", active_id_o, 0);
    chk("rst_vld", claim_vld_o, 0);
    chk("rst_err", cmpl_err_o, 0);
    rst = 1'b0;
    tick();
    chk("rst_ext_lat1", ext_irq_o, 0);
    tick();
    chk("rst_ext_lat2", ext_irq_o, 1);
    do_claim();
    chk("rst_claim_vld", claim_vld_o, 1);
    chk("rst_claim_id", claim_id_o, 3);
    chk("rst_claim_act", active_id_o, 3);
    chk("rst_claim_ext", ext_irq_o, 0);
    do_complete(3);
    chk("rst_cmpl_act", active_id_o, 0);
    irq = 4'b0000;
    repeat (4) tick();

    // spurious claim and completion while idle
    do_claim();
    chk("idle_claim_vld", claim_vld_o, 1);
    chk("idle_claim_id", claim_id_o, 0);
    do_complete(1);
    chk("idle_cmpl_err", cmpl_err_o, 1);
    tick();
    chk("idle_err_pulse", cmpl_err_o, 0);

`ifdef PLIC_CLAIM_EDGE_EN
    // one-cycle pulse is latched
    irq = 4'b0001; tick(); irq = 4'b0000;
    wait_ext(4, "edge_ext");
    do_claim();
    chk("edge_id1", claim_id_o, 1);
    // second pulse during service is held
    tick();
    irq = 4'b0001; tick(); irq = 4'b0000;
    tick();
    chk("edge_serv_ext", ext_irq_o, 0);
    do_complete(1);
    chk("edge_cmpl_ext", ext_irq_o, 1);
    do_claim();
    chk("edge_id1_again", claim_id_o, 1);
    do_complete(1);
    repeat (2) tick();
    // pend = 1010 built from one-hot pulses
    irq = 4'b0010; tick(); irq = 4'b1000; tick(); irq = 4'b0000; tick();
    wait_ext(4, "edge_prio_ext");
    do_claim();
    chk("edge_prio_id2", claim_id_o, 2);
    do_complete(2);
    do_claim();
    chk("edge_prio_id4", claim_id_o, 4);
    do_complete(4);
    repeat (2) tick();
    // enable drop clears the held bit
    irq = 4'b0010; tick(); irq = 4'b1000; tick(); irq = 4'b0000; tick();
    wait_ext(4, "edge_en_ext");
    do_claim();
    chk("edge_en_id2", claim_id_o, 2);
    irq_en = 4'b0111; tick();
    do_complete(2);
    do_claim();
    chk("edge_en_vld", claim_vld_o, 1);
    chk("edge_en_id0", claim_id_o, 0);
    irq_en = 4'hF;
    repeat (3) tick();
`else
    // basic flow
    irq = 4'b0010;
    wait_ext(6, "basic_ext");
    do_claim();
    chk("basic_vld", claim_vld_o, 1);
    chk("basic_id", claim_id_o, 2);
    chk("basic_act", active_id_o, 2);
    chk("basic_ext_lo", ext_irq_o, 0);
    tick();
    chk("basic_vld_1cyc", claim_vld_o, 0);
    do_complete(2);
    chk("basic_cmpl_act", active_id_o, 0);
    chk("basic_cmpl_err", cmpl_err_o, 0);
    wait_ext(4, "basic_ext_again");
    // switch request to source 0, claim it
    irq = 4'b0001;
    tick(); tick();
    do_claim();
    chk("err_setup_id", claim_id_o, 1);
    // mismatched completion
    do_complete(3);
    chk("err_pulse", cmpl_err_o, 1);
    chk("err_act_kept", active_id_o, 1);
    tick();
    chk("err_pulse_end", cmpl_err_o, 0);
    // claim and matching completion in one cycle
    claim = 1'b1; complete = 1'b1; complete_id = 3'd1;
    tick();
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    chk("coll_vld", claim_vld_o, 1);
    chk("coll_id", claim_id_o, 0);
    chk("coll_act", active_id_o, 0);
    irq = 4'b0000;
    repeat (3) tick();
    // priority: two sources, lowest first
    irq = 4'b1010;
    wait_ext(4, "prio_ext");
    do_claim();
    chk("prio_id2", claim_id_o, 2);
    do_complete(2);
    do_claim();
    chk("prio_id4", claim_id_o, 4);
    do_complete(4);
    irq = 4'b0000;
    repeat (3) tick();
    // enable dropped before second claim
    irq = 4'b1010;
    wait_ext(4, "en_ext");
    do_claim();
    chk("en_id2", claim_id_o, 2);
    irq_en = 4'b0111; tick();
    do_complete(2);
    do_claim();
    chk("en_vld", claim_vld_o, 1);
    chk("en_id0", claim_id_o, 0);
    irq_en = 4'hF; irq = 4'b0000;
    repeat (3) tick();
    // reset mid-service
    irq = 4'b0001;
    wait_ext(4, "rms_ext");
    do_claim();
    chk("rms_act", active_id_o, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rms_act_clr", active_id_o, 0);
    chk("rms_ext_clr", ext_irq_o, 0);
    irq = 4'b0000;
    repeat (3) tick();
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
